// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  // Iteration counter must be able to hold BIN_W itself.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a binary-count producer and the BCD converter.
// Handshake: start is a valid strobe, !busy is ready; a transfer happens on a clock edge with start && !busy.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  busy;
    logic                  done;
    logic                  ovf;

    modport master (
        output start, bin_in,
        input  bcd_out, busy, done, ovf
    );

    modport slave (
        input  start, bin_in,
        output bcd_out, busy, done, ovf
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Single BCD digit pre-shift correction: values of 5 or more get 3 added.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);
    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + ADJ_ADD) : i_digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-packed-BCD converter, one bit per clock.
// Optional BCD_SATURATE_EN: overflowing results are shown as all-9s instead of the low digits.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bin_to_bcd_seq_if.slave      bus,
    output state_t               o_dbg_state
);
    localparam int SCR_W = (DIGITS + 1) * DIGIT_W;
    localparam int OUT_W = DIGITS * DIGIT_W;
    localparam int CNT_W = cnt_width(BIN_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    state_t              r_state;
    state_t              w_next;
    logic [BIN_W-1:0]    r_shift;
    logic [SCR_W-1:0]    r_scratch;
    logic [SCR_W-1:0]    w_adj;
    logic [CNT_W-1:0]    r_cnt;
    logic [OUT_W-1:0]    r_bcd;
    logic [OUT_W-1:0]    w_result;
    logic                r_ovf;
    logic                r_done;
    logic                w_busy;
    logic                w_ovf;

    for (genvar g = 0; g <= DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start)          w_next = CONV;
            CONV:    if (r_cnt == LAST_ITER) w_next = FIN;
            FIN:                             w_next = IDLE;
            default:                         w_next = IDLE;
        endcase
    end

    // The extra top digit only catches values beyond DIGITS decimal digits.
    always_comb begin
        w_busy = (r_state != IDLE);
        w_ovf  = |r_scratch[SCR_W-1 -: DIGIT_W];
`ifdef BCD_SATURATE_EN
        w_result = w_ovf ? {DIGITS{4'd9}} : r_scratch[OUT_W-1:0];
`else
        w_result = r_scratch[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == FIN);
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shift   <= bus.bin_in;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                    end
                end
                CONV: begin
                    r_scratch <= {w_adj[SCR_W-2:0], r_shift[BIN_W-1]};
                    r_shift   <= {r_shift[BIN_W-2:0], 1'b0};
                    r_cnt     <= r_cnt + 1'b1;
                end
                FIN: begin
                    r_bcd <= w_result;
                    r_ovf <= w_ovf;
                end
                default: ;
            endcase
        end
    end

    assign bus.bcd_out  = r_bcd;
    assign bus.busy     = w_busy;
    assign bus.done     = r_done;
    assign bus.ovf      = r_ovf;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq: reset, nominal, overflow, busy-start, back-to-back and strided sweep.
module tb_bin_to_bcd_seq;
    import bcd_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     n_checks;
    int     n_fail;

    bin_to_bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus ();

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic check_inv();
        logic ok;
        ok = !(bus.done && bus.busy);
        for (int i = 0; i < 4; i++)
            if (bus.bcd_out[i*4 +: 4] > 4'd9) ok = 1'b0;
        check("invariant", 32'(ok), 32'd1);
    endtask

    // Issues one start and waits for done; lat counts clocks from the accepting edge.
    task automatic run_conv(input int v, output logic [15:0] bcd, output logic ovf, output int lat);
        bus.start  = 1'b1;
        bus.bin_in = 14'(v);
        tick();
        bus.start = 1'b0;
        check("accept_busy", 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
            check_inv();
        end
        if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
        bcd = bus.bcd_out;
        ovf = bus.ovf;
    endtask

    initial begin
        logic [15:0] bcd;
        logic        ovf;
        int          lat;
        int          dones;
        logic [15:0] sat_exp;

        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        tick();
        tick();
        check("rst_busy",  32'(bus.busy),    32'd0);
        check("rst_done",  32'(bus.done),    32'd0);
        check("rst_ovf",   32'(bus.ovf),     32'd0);
        check("rst_bcd",   32'(bus.bcd_out), 32'h0000);
        check("rst_state", 32'(dbg_state),   32'(IDLE));
        rst = 1'b0;
        tick();

        run_conv(1234, bcd, ovf, lat);
        check("n1234_bcd", 32'(bcd), 32'h1234);
        check("n1234_ovf", 32'(ovf), 32'd0);
        check("n1234_lat", 32'(lat), 32'd15);
        tick();
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("hold_bcd", 32'(bus.bcd_out), 32'h1234);

        run_conv(9999, bcd, ovf, lat);
        check("n9999_bcd", 32'(bcd), 32'h9999);
        check("n9999_ovf", 32'(ovf), 32'd0);

`ifdef BCD_SATURATE_EN
        sat_exp = 16'h9999;
`else
        sat_exp = 16'h6383;
`endif
        run_conv(16383, bcd, ovf, lat);
        check("ovf_bcd", 32'(bcd), 32'(sat_exp));
        check("ovf_flag", 32'(ovf), 32'd1);

        run_conv(10000, bcd, ovf, lat);
        check("ovf10k_flag", 32'(ovf), 32'd1);
        tick();

        // Reset in the middle of a conversion; earlier overflow result must be wiped.
        bus.start  = 1'b1;
        bus.bin_in = 14'd1234;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("mid_rst_busy",  32'(bus.busy),    32'd0);
        check("mid_rst_bcd",   32'(bus.bcd_out), 32'h0000);
        check("mid_rst_ovf",   32'(bus.ovf),     32'd0);
        check("mid_rst_state", 32'(dbg_state),   32'(IDLE));
        dones = 0;
        repeat (25) begin
            tick();
            if (bus.done) dones++;
        end
        check("mid_rst_no_done", 32'(dones), 32'd0);

        run_conv(0, bcd, ovf, lat);
        check("zero_bcd", 32'(bcd), 32'h0000);
        check("zero_ovf", 32'(ovf), 32'd0);
        check("zero_lat", 32'(lat), 32'd15);
        tick();

        // Start pulse while busy is dropped; bin_in change after acceptance is ignored.
        bus.start  = 1'b1;
        bus.bin_in = 14'd42;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start  = 1'b1;
        bus.bin_in = 14'd77;
        tick();
        bus.start = 1'b0;
        dones = 0;
        repeat (40) begin
            if (bus.done) begin
                dones++;
                check("busy_start_bcd", 32'(bus.bcd_out), 32'h0042);
            end
            tick();
        end
        check("busy_start_dones", 32'(dones), 32'd1);
        check("busy_start_final", 32'(bus.bcd_out), 32'h0042);

        // Back-to-back: new start issued in the done cycle.
        run_conv(1234, bcd, ovf, lat);
        check("b2b_first_bcd", 32'(bcd), 32'h1234);
        bus.start  = 1'b1;
        bus.bin_in = 14'd500;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            check("b2b_hold", 32'(bus.bcd_out), 32'h1234);
            tick();
            lat++;
        end
        check("b2b_gap", 32'(lat), 32'd16);
        check("b2b_bcd", 32'(bus.bcd_out), 32'h0500);
        check("b2b_ovf", 32'(bus.ovf), 32'd0);
        tick();

        for (int v = 0; v <= 9999; v += 7) begin
            run_conv(v, bcd, ovf, lat);
            check("sweep_bcd", 32'(bcd), 32'(ref_bcd(v)));
            check("sweep_ovf", 32'(ovf), 32'd0);
        end
        run_conv(9998, bcd, ovf, lat);
        check("sweep_9998", 32'(bcd), 32'h9998);
        run_conv(1000, bcd, ovf, lat);
        check("sweep_1000", 32'(bcd), 32'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
